// File: rtl/validity_mask_generator.sv
// Splits an input word stream into segments and tags each word with per-byte validity and a last flag.
// Optional feature macro: VALIDITY_PAD_EN (adds dout_pad and an extra pad word on word-aligned segment ends).
module validity_mask_generator #(
  parameter int BUS_SIZE = 32,
  parameter int LEN_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LEN_SIZE-1:0]     seg_len,
  input  logic                    seg_start,
  output logic                    seg_busy,
  input  logic [BUS_SIZE-1:0]     din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [BUS_SIZE-1:0]     dout,
  output logic [BUS_SIZE/8-1:0]   dout_validity,
  output logic                    dout_last,
`ifdef VALIDITY_PAD_EN
  output logic [BUS_SIZE/8-1:0]   dout_pad,
`endif
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  localparam int BYTES = BUS_SIZE / 8;
  localparam logic [LEN_SIZE-1:0] BYTES_L = LEN_SIZE'(BYTES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
`ifdef VALIDITY_PAD_EN
  localparam logic [1:0] ST_PAD   = 2'd3;
`endif

  // Bytes with index below the remaining count belong to the segment.
  function automatic logic [BYTES-1:0] validity_mask(input logic [LEN_SIZE-1:0] rem);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (LEN_SIZE'(i) < rem);
    end
    return m;
  endfunction

`ifdef VALIDITY_PAD_EN
  function automatic logic [BYTES-1:0] pad_onehot(input logic [LEN_SIZE-1:0] rem);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (LEN_SIZE'(i) == rem);
    end
    return m;
  endfunction
`endif

  logic [1:0]          state_r;
  logic [LEN_SIZE-1:0] rem_r;
  logic [BUS_SIZE-1:0] dout_r;
  logic [BYTES-1:0]    validity_r;
  logic                last_r;
  logic                dout_valid_r;
`ifdef VALIDITY_PAD_EN
  logic [BYTES-1:0]    pad_r;
`endif

  logic                out_hs_s;
  logic                out_free_s;
  logic                din_ready_s;
  logic                in_hs_s;
  logic [LEN_SIZE-1:0] take_s;
  logic                end_word_s;
  logic                last_s;

  assign out_hs_s    = dout_valid_r & dout_ready;
  assign out_free_s  = ~dout_valid_r | dout_ready;
  assign din_ready_s = (state_r == ST_RUN) & out_free_s;
  assign in_hs_s     = din_valid & din_ready_s;
  assign take_s      = (rem_r >= BYTES_L) ? BYTES_L : rem_r;
  assign end_word_s  = (rem_r <= BYTES_L);
`ifdef VALIDITY_PAD_EN
  // A word-aligned end defers the last flag to the following pad word.
  assign last_s      = (rem_r < BYTES_L);
`else
  assign last_s      = end_word_s;
`endif

  assign seg_busy      = (state_r != ST_IDLE);
  assign din_ready     = din_ready_s;
  assign dout          = dout_r;
  assign dout_validity = validity_r;
  assign dout_last     = last_r;
  assign dout_valid    = dout_valid_r;
`ifdef VALIDITY_PAD_EN
  assign dout_pad      = pad_r;
`endif

  // Segment state, remaining byte count and the output word register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rem_r        <= {LEN_SIZE{1'b0}};
      dout_r       <= {BUS_SIZE{1'b0}};
      validity_r   <= {BYTES{1'b0}};
      last_r       <= 1'b0;
      dout_valid_r <= 1'b0;
`ifdef VALIDITY_PAD_EN
      pad_r        <= {BYTES{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (seg_start && (seg_len != {LEN_SIZE{1'b0}})) begin
            rem_r   <= seg_len;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_hs_s) begin
            rem_r <= rem_r - take_s;
            if (end_word_s) begin
`ifdef VALIDITY_PAD_EN
              state_r <= (rem_r == BYTES_L) ? ST_PAD : ST_FLUSH;
`else
              state_r <= ST_FLUSH;
`endif
            end
          end
        end
`ifdef VALIDITY_PAD_EN
        ST_PAD: begin
          if (out_free_s) begin
            state_r <= ST_FLUSH;
          end
        end
`endif
        ST_FLUSH: begin
          if (out_hs_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (in_hs_s) begin
        dout_r       <= din;
        validity_r   <= validity_mask(rem_r);
        last_r       <= last_s;
        dout_valid_r <= 1'b1;
`ifdef VALIDITY_PAD_EN
        pad_r        <= pad_onehot(rem_r);
      end else if ((state_r == ST_PAD) && out_free_s) begin
        dout_r       <= {BUS_SIZE{1'b0}};
        validity_r   <= {BYTES{1'b0}};
        last_r       <= 1'b1;
        dout_valid_r <= 1'b1;
        pad_r        <= {{(BYTES-1){1'b0}}, 1'b1};
`endif
      end else if (out_hs_s) begin
        dout_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_validity_mask_generator.sv
// Randomized self-checking bench for validity_mask_generator against a segment-level reference model.
module tb_validity_mask_generator;

  localparam int BUS_SIZE = 32;
  localparam int LEN_SIZE = 16;
  localparam int NB       = BUS_SIZE / 8;
`ifdef VALIDITY_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [LEN_SIZE-1:0] seg_len = '0;
  logic                seg_start = 1'b0;
  logic                seg_busy;
  logic [BUS_SIZE-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic [BUS_SIZE-1:0] dout;
  logic [NB-1:0]       dout_validity;
  logic                dout_last;
  logic                dout_valid;
  logic                dout_ready = 1'b0;
`ifdef VALIDITY_PAD_EN
  logic [NB-1:0]       dout_pad;
`endif

  validity_mask_generator #(.BUS_SIZE(BUS_SIZE), .LEN_SIZE(LEN_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_len(seg_len), .seg_start(seg_start), .seg_busy(seg_busy),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_validity(dout_validity), .dout_last(dout_last),
`ifdef VALIDITY_PAD_EN
    .dout_pad(dout_pad),
`endif
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_SIZE-1:0] data;
    logic [NB-1:0]       vld;
    logic                last;
    logic [NB-1:0]       pad;
  } word_t;

  word_t               obs[$];
  word_t               exp_q[$];
  logic [BUS_SIZE-1:0] words[64];
  int                  in_cnt;
  int                  mode;
  int                  errors = 0;
  int                  checks = 0;
  bit                  prev_stall = 1'b0;
  word_t               prev_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t cur_word();
    word_t w;
    w.data = dout;
    w.vld  = dout_validity;
    w.last = dout_last;
`ifdef VALIDITY_PAD_EN
    w.pad  = dout_pad;
`else
    w.pad  = '0;
`endif
    return w;
  endfunction

  // One clock: sample at negedge, then drive new inputs just after posedge.
  task automatic cycle();
    word_t w;
    @(negedge clk);
    w = cur_word();
    if (prev_stall) begin
      check("hold_data", dout, prev_w.data);
      check("hold_vld", dout_validity, prev_w.vld);
      check("hold_last", dout_last, prev_w.last);
      check("hold_valid", dout_valid, 1);
    end
    if (rst_n && dout_valid && dout_ready) obs.push_back(w);
    if (rst_n && din_valid && din_ready) in_cnt++;
    prev_stall = rst_n && dout_valid && !dout_ready;
    prev_w = w;
    @(posedge clk);
    #1;
    seg_start = 1'b0;
    case (mode)
      0: begin din_valid = 1'b1; dout_ready = 1'b1; end
      1: begin din_valid = 1'($urandom_range(0, 1)); dout_ready = ~dout_ready; end
      2: begin din_valid = 1'($urandom_range(0, 1)); dout_ready = 1'($urandom_range(0, 1)); end
      3: begin din_valid = 1'b1; dout_ready = 1'b0; end
      default: begin din_valid = 1'b0; dout_ready = 1'b1; end
    endcase
    din = words[(in_cnt < 64) ? in_cnt : 63];
  endtask

  task automatic check_reset();
    check("rst_dout", dout, 0);
    check("rst_vld", dout_validity, 0);
    check("rst_last", dout_last, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", seg_busy, 0);
    check("rst_din_ready", din_ready, 0);
  endtask

  task automatic fill_words();
    for (int i = 0; i < 64; i++) words[i] = $urandom;
  endtask

  task automatic run_seg(input int len, input int m, input bit poke);
    int n;
    int b;
    word_t e;
    fill_words();
    obs.delete();
    exp_q.delete();
    in_cnt = 0;
    n = (len + NB - 1) / NB;
    for (int k = 0; k < n; k++) begin
      int v;
      v = len - NB * k;
      if (v > NB) v = NB;
      e.data = words[k];
      e.vld  = NB'((1 << v) - 1);
      e.last = (k == n - 1);
      e.pad  = '0;
      if (PAD && k == n - 1) begin
        if (len % NB == 0) e.last = 1'b0;
        else e.pad = NB'(1 << (len % NB));
      end
      exp_q.push_back(e);
    end
    if (PAD && len % NB == 0) begin
      e.data = '0; e.vld = '0; e.last = 1'b1; e.pad = NB'(1);
      exp_q.push_back(e);
    end

    mode = m;
    seg_len = LEN_SIZE'(len);
    seg_start = 1'b1;
    din = words[0];
    if (m == 0) begin din_valid = 1'b1; dout_ready = 1'b1; end
    cycle();
    #1;
    check("busy_on", seg_busy, 1);
    if (m == 0) check("ready_1cyc", din_ready, 1);

    b = 0;
    while (obs.size() < exp_q.size() && b < 400) begin
      if (poke && b == 2) begin seg_len = 16'd3; seg_start = 1'b1; end
      cycle();
      b++;
    end
    check("out_count", obs.size(), exp_q.size());
    check("busy_drop", seg_busy, 0);
    mode = 0;
    repeat (3) cycle();
    check("no_extra_out", obs.size(), exp_q.size());
    check("in_count", in_cnt, n);
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check("data", obs[i].data, exp_q[i].data);
      check("validity", obs[i].vld, exp_q[i].vld);
      check("last", obs[i].last, exp_q[i].last);
      check("pad", obs[i].pad, exp_q[i].pad);
    end
  endtask

  initial begin
    fill_words();
    mode = 0;
    in_cnt = 0;
    rst_n = 1'b0;
    cycle();
    cycle();
    check_reset();
    rst_n = 1'b1;

    run_seg(10, 0, 1'b0);
    run_seg(8, 0, 1'b0);
    run_seg(5, 0, 1'b0);
    run_seg(12, 1, 1'b0);
    run_seg(10, 0, 1'b1);

    // Zero-length command is ignored.
    seg_len = '0;
    seg_start = 1'b1;
    cycle();
    #1;
    check("zero_busy", seg_busy, 0);
    check("zero_din_ready", din_ready, 0);
    cycle();
    cycle();
    check("zero_no_out", dout_valid, 0);

    // Reset while a word is stalled in the output register.
    fill_words();
    in_cnt = 0;
    mode = 3;
    seg_len = 16'd12;
    seg_start = 1'b1;
    cycle();
    cycle();
    cycle();
    check("pre_rst_valid", dout_valid, 1);
    rst_n = 1'b0;
    cycle();
    prev_stall = 1'b0;
    rst_n = 1'b1;
    check_reset();
    run_seg(4, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_seg($urandom_range(1, 40), $urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
